// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch front end. Drives a word address to a
// combinational instruction memory, registers the returned word with a
// one-cycle latency and hands it to decode over a valid/ready handshake.
// Redirects (taken branches/jumps) flush the held instruction and refetch.
// Optional build macro FETCH_HALT_ON_ZERO_EN: an all-zero instruction word
// parks the sequencer in HALT until a redirect or reset.
module fetch_sequencer #(
  parameter int          ADDR_W   = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_data,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc;
  logic              transfer;
  logic              do_fetch;
  logic              hit_zero;

  // The memory always sees the current pc; the word comes back this cycle.
  assign i_mem_addr = pc;

  // Decode consumes the held instruction this cycle.
  assign transfer = instr_valid & instr_ready;

  // A new word is captured when fetching is allowed and the output slot is
  // empty or being emptied; a redirect suppresses the capture.
  assign do_fetch = (state_q == S_FETCH) & fetch_en & ~redirect_valid &
                    (~instr_valid | transfer);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign hit_zero = do_fetch & (i_mem_data == 32'd0);
`else
  assign hit_zero = 1'b0;
`endif

  // State register.
  // NOTE: clocked state uses non-blocking (<=) assignments so every register
  // samples pre-edge values and the simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: redirect wins, otherwise fetch_en gates IDLE/FETCH.
  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = fetch_en ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (fetch_en) state_d = S_FETCH;
        S_FETCH: begin
          if (hit_zero)       state_d = S_HALT;
          else if (!fetch_en) state_d = S_IDLE;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode: halted reflects the HALT state only when the feature exists.
  always_comb begin
`ifdef FETCH_HALT_ON_ZERO_EN
    halted = (state_q == S_HALT);
`else
    halted = 1'b0;
`endif
  end

  // Datapath: pc, the output instruction register and its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_ADDR;
      instr_out   <= 32'd0;
      pc_out      <= RESET_ADDR;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      // Flush whatever is held and restart from the target next cycle.
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
    end else if (do_fetch) begin
      instr_out   <= i_mem_data;
      pc_out      <= pc;
      instr_valid <= 1'b1;
      // A halting word freezes pc so nothing beyond it is fetched.
      if (!hit_zero) begin
        pc <= pc + ADDR_W'(1);
      end
    end else if (transfer) begin
      // Slot drained with no refill (IDLE, HALT or fetch_en low).
      instr_valid <= 1'b0;
    end
  end

endmodule
